// File: rtl/fa_bist_pkg.sv
// Shared types, sizes and golden model for the full-adder self-test block.
package fa_bist_pkg;

  localparam int unsigned VEC_COUNT = 8;
  localparam int unsigned VEC_W     = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_MAX   = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } bist_state_e;

  // Stimulus payload; bit order matches the vector index {a,b,cin}.
  typedef struct packed {
    logic a;
    logic b;
    logic cin;
  } fa_vec_t;

  function automatic logic exp_sum(input logic [VEC_W-1:0] vec);
    return ^vec;
  endfunction

  function automatic logic exp_carry(input logic [VEC_W-1:0] vec);
    return (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/fa_bist_ctrl.sv
// Sequencer for the full-adder self-test: FSM, settle timer, vector and sweep counters.
module fa_bist_ctrl
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output fa_vec_t          stim,
  output logic [VEC_W-1:0] vec,
  output logic             start_acc_c,
  output logic             check_c
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PASS_LAST   = CNT_W'(PASSES);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(VEC_COUNT - 1);

  bist_state_e      state, state_nxt;
  logic [CNT_W-1:0] scnt, scnt_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic [VEC_W-1:0] vec_nxt;
  fa_vec_t          stim_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      scnt  <= '0;
      pcnt  <= '0;
      vec   <= '0;
      stim  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      pcnt  <= pcnt_nxt;
      vec   <= vec_nxt;
      stim  <= stim_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    pcnt_nxt    = pcnt;
    vec_nxt     = vec;
    start_acc_c = 1'b0;
    check_c     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc_c = 1'b1;
          vec_nxt     = '0;
          pcnt_nxt    = '0;
          state_nxt   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        scnt_nxt  = SETTLE_LOAD;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (scnt == '0) begin
          state_nxt = ST_CHECK;
        end else begin
          scnt_nxt = scnt - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        check_c   = 1'b1;
        vec_nxt   = vec + VEC_W'(1);
        state_nxt = ST_APPLY;
        if (vec == VEC_LAST) begin
          pcnt_nxt = pcnt + CNT_W'(1);
          if (pcnt_nxt == PASS_LAST) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Stimulus tracks the vector only while a vector is in flight; idle/done drive zero.
    stim_nxt = '0;
    if ((state_nxt == ST_APPLY) || (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK)) begin
      stim_nxt = fa_vec_t'(vec_nxt);
    end
    busy_nxt = (state != ST_IDLE);
    done_nxt = (state == ST_DONE);
  end

endmodule

// File: rtl/full_adder_bist.sv
// Self-test initiator for a 1-bit full adder: sweeps all inputs and scores the responses.
module full_adder_bist
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             sum,
  input  logic             carry
);

  fa_vec_t          stim;
  logic [VEC_W-1:0] vec;
  logic             start_acc_c;
  logic             check_c;
  logic             mismatch_c;
  logic             first_fail;

  fa_bist_ctrl #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .PASSES        (PASSES)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .stim        (stim),
    .vec         (vec),
    .start_acc_c (start_acc_c),
    .check_c     (check_c)
  );

  assign a   = stim.a;
  assign b   = stim.b;
  assign cin = stim.cin;

  assign mismatch_c = check_c && ((sum != exp_sum(vec)) || (carry != exp_carry(vec)));

  // Result registers: cleared on an accepted start, held after the run ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      first_fail <= 1'b0;
    end else if (start_acc_c) begin
      pass       <= 1'b1;
      err_count  <= '0;
      fail_vec   <= '0;
      first_fail <= 1'b0;
    end else if (mismatch_c) begin
      pass <= 1'b0;
      if (err_count != CNT_W'(ERR_MAX)) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (!first_fail) begin
        fail_vec   <= vec;
        first_fail <= 1'b1;
      end
    end
  end

endmodule
